// File: rtl/se_gap_reader_pkg.sv
// Shared definitions for the SE global-average-pool reader.
// Holds the FSM state encoding, lane geometry, int8 saturation limits and
// the fixed-point constants used when scaling lane sums by the reciprocal.
package se_gap_reader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_RUN   = 3'd1;
  localparam state_t ST_DRAIN = 3'd2;
  localparam state_t ST_CALC  = 3'd3;
  localparam state_t ST_OUT   = 3'd4;
  localparam state_t ST_FIN   = 3'd5;

  localparam int LANES      = 4;
  localparam int LANE_W     = 8;
  localparam int INT8_MAX   = 127;
  localparam int INT8_MIN   = -128;
  localparam int RECIP_FRAC = 16;
  localparam int ROUND_BIAS = 32768;

endpackage

// File: rtl/se_gap_reader_if.sv
// Mean-word stream from the squeeze stage to the SE excitation stage.
// Ports: gap_valid/gap_ready handshake, gap_data (4 packed int8 means),
// gap_group (channel-group index of gap_data).
// master = producer (se_gap_reader), slave = consumer.
interface se_gap_reader_if
  import se_gap_reader_pkg::*;
#(
  parameter int DATA_WIDTH = LANES * LANE_W,
  parameter int GRP_WIDTH  = 10
);
  logic                  gap_valid;
  logic                  gap_ready;
  logic [DATA_WIDTH-1:0] gap_data;
  logic [GRP_WIDTH-1:0]  gap_group;

  modport master (output gap_valid, output gap_data, output gap_group, input gap_ready);
  modport slave  (input gap_valid, input gap_data, input gap_group, output gap_ready);
endinterface

// File: rtl/se_gap_reader_gap_lane_scale.sv
// Combinational per-lane mean: (acc * recip + 2^15) >>> 16, saturated to int8.
// Ports: acc_i (signed lane sum), recip_i (unsigned Q0.16 reciprocal),
// mean_o (int8 mean, two's complement).
module se_gap_reader_gap_lane_scale
  import se_gap_reader_pkg::*;
#(
  parameter int ACC_WIDTH   = 24,
  parameter int RECIP_WIDTH = 16
) (
  input  logic signed [ACC_WIDTH-1:0]   acc_i,
  input  logic        [RECIP_WIDTH-1:0] recip_i,
  output logic        [LANE_W-1:0]      mean_o
);

  // One extra bit keeps the unsigned reciprocal positive in the signed product.
  localparam int PROD_W = ACC_WIDTH + RECIP_WIDTH + 1;

  logic signed [PROD_W-1:0] prod_s;
  logic signed [PROD_W-1:0] rnd_s;
  logic signed [PROD_W-1:0] shf_s;

  // Scale, round half up, floor-shift and clamp to the int8 range.
  always_comb begin
    prod_s = PROD_W'(acc_i) * PROD_W'($signed({1'b0, recip_i}));
    rnd_s  = prod_s + PROD_W'(ROUND_BIAS);
    shf_s  = rnd_s >>> RECIP_FRAC;
    if (shf_s > PROD_W'(INT8_MAX)) begin
      mean_o = LANE_W'(INT8_MAX);
    end else if (shf_s < PROD_W'(INT8_MIN)) begin
      mean_o = LANE_W'(INT8_MIN);
    end else begin
      mean_o = shf_s[LANE_W-1:0];
    end
  end

endmodule

// File: rtl/se_gap_reader.sv
// Global-average-pool reader for the SE block.
// Walks the OFM buffer one channel group at a time, sums each int8 lane over
// all pixels, scales by the host reciprocal and emits one packed mean word
// per group.
// Ports: clk, rst_n (async active-low); start + num_pixels/num_groups/recip
// config (sampled on start); bram_rd_addr/bram_rd_data buffer read port
// (1-cycle latency, byte address); busy/done status; gap_if mean stream.
module se_gap_reader
  import se_gap_reader_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 20,
  parameter int ACC_WIDTH   = 24,
  parameter int RECIP_WIDTH = 16,
  parameter int CNT_WIDTH   = 16,
  parameter int GRP_WIDTH   = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CNT_WIDTH-1:0]   num_pixels,
  input  logic [GRP_WIDTH-1:0]   num_groups,
  input  logic [RECIP_WIDTH-1:0] recip,
  output logic [ADDR_WIDTH-1:0]  bram_rd_addr,
  input  logic [DATA_WIDTH-1:0]  bram_rd_data,
  output logic                   busy,
  output logic                   done,
  se_gap_reader_if.master        gap_if
);

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    np_q, np_d;
  logic [GRP_WIDTH-1:0]    ng_q, ng_d;
  logic [RECIP_WIDTH-1:0]  recip_q, recip_d;
  logic [GRP_WIDTH-1:0]    g_q, g_d;
  logic [CNT_WIDTH-1:0]    p_q, p_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;     // byte address of pixel 0 of group g
  logic [ADDR_WIDTH-1:0]   stride_q, stride_d; // num_groups*4: one pixel step
  logic                    rd_vld_q, rd_vld_d;
  logic signed [ACC_WIDTH-1:0] acc_q [LANES];
  logic signed [ACC_WIDTH-1:0] acc_d [LANES];
  logic [DATA_WIDTH-1:0]   gap_data_q, gap_data_d;
  logic [GRP_WIDTH-1:0]    gap_group_q, gap_group_d;
  logic                    gap_valid_q, gap_valid_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [LANES-1:0][LANE_W-1:0] mean_s;

  // Four lane scalers, consumed only in CALC when the sums are final.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    se_gap_reader_gap_lane_scale #(
      .ACC_WIDTH   (ACC_WIDTH),
      .RECIP_WIDTH (RECIP_WIDTH)
    ) u_scale (
      .acc_i   (acc_q[l]),
      .recip_i (recip_q),
      .mean_o  (mean_s[l])
    );
  end

  // Next-state, address walk, accumulation and output staging.
  always_comb begin
    state_d     = state_q;
    np_d        = np_q;
    ng_d        = ng_q;
    recip_d     = recip_q;
    g_d         = g_q;
    p_d         = p_q;
    addr_d      = addr_q;
    base_d      = base_q;
    stride_d    = stride_q;
    gap_data_d  = gap_data_q;
    gap_group_d = gap_group_q;
    gap_valid_d = gap_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    // Read data returns one cycle after an address issued in RUN.
    rd_vld_d    = (state_q == ST_RUN);
    for (int l = 0; l < LANES; l++) begin
      if (rd_vld_q) begin
        acc_d[l] = acc_q[l] + ACC_WIDTH'($signed(bram_rd_data[l*LANE_W +: LANE_W]));
      end else begin
        acc_d[l] = acc_q[l];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          np_d     = num_pixels;
          ng_d     = num_groups;
          recip_d  = recip;
          busy_d   = 1'b1;
          g_d      = {GRP_WIDTH{1'b0}};
          p_d      = {CNT_WIDTH{1'b0}};
          base_d   = {ADDR_WIDTH{1'b0}};
          stride_d = ADDR_WIDTH'({num_groups, 2'b00});
          if ((num_pixels == {CNT_WIDTH{1'b0}}) || (num_groups == {GRP_WIDTH{1'b0}})) begin
            state_d = ST_FIN;
          end else begin
            addr_d  = {ADDR_WIDTH{1'b0}};
            for (int l = 0; l < LANES; l++) acc_d[l] = {ACC_WIDTH{1'b0}};
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // The last address is left in place so it holds outside RUN.
        if (p_q == (np_q - CNT_WIDTH'(1))) begin
          state_d = ST_DRAIN;
        end else begin
          p_d    = p_q + CNT_WIDTH'(1);
          addr_d = addr_q + stride_q;
        end
      end
      ST_DRAIN: begin
        state_d = ST_CALC;
      end
      ST_CALC: begin
        gap_data_d  = DATA_WIDTH'(mean_s);
        gap_group_d = g_q;
        gap_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (gap_if.gap_ready) begin
          gap_valid_d = 1'b0;
          if (g_q == (ng_q - GRP_WIDTH'(1))) begin
            state_d = ST_FIN;
          end else begin
            g_d     = g_q + GRP_WIDTH'(1);
            p_d     = {CNT_WIDTH{1'b0}};
            base_d  = base_q + ADDR_WIDTH'(4);
            addr_d  = base_q + ADDR_WIDTH'(4);
            for (int l = 0; l < LANES; l++) acc_d[l] = {ACC_WIDTH{1'b0}};
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_OUT;
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any run silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      np_q        <= {CNT_WIDTH{1'b0}};
      ng_q        <= {GRP_WIDTH{1'b0}};
      recip_q     <= {RECIP_WIDTH{1'b0}};
      g_q         <= {GRP_WIDTH{1'b0}};
      p_q         <= {CNT_WIDTH{1'b0}};
      addr_q      <= {ADDR_WIDTH{1'b0}};
      base_q      <= {ADDR_WIDTH{1'b0}};
      stride_q    <= {ADDR_WIDTH{1'b0}};
      rd_vld_q    <= 1'b0;
      for (int l = 0; l < LANES; l++) acc_q[l] <= {ACC_WIDTH{1'b0}};
      gap_data_q  <= {DATA_WIDTH{1'b0}};
      gap_group_q <= {GRP_WIDTH{1'b0}};
      gap_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      np_q        <= np_d;
      ng_q        <= ng_d;
      recip_q     <= recip_d;
      g_q         <= g_d;
      p_q         <= p_d;
      addr_q      <= addr_d;
      base_q      <= base_d;
      stride_q    <= stride_d;
      rd_vld_q    <= rd_vld_d;
      for (int l = 0; l < LANES; l++) acc_q[l] <= acc_d[l];
      gap_data_q  <= gap_data_d;
      gap_group_q <= gap_group_d;
      gap_valid_q <= gap_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bram_rd_addr     = addr_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign gap_if.gap_valid = gap_valid_q;
  assign gap_if.gap_data  = gap_data_q;
  assign gap_if.gap_group = gap_group_q;

endmodule
